// File: rtl/reveal_engine.sv
// reveal_engine: stack-based flood-fill reveal/flag controller for a 16x16 minesweeper field.
// Defining REVEAL_ALL_ON_LOSS_EN adds a SWEEP state that shows every unflagged mine after a loss.
module reveal_engine #(
  parameter int unsigned MINES = 40
) (
  input  logic       VGA_CLK,
  input  logic       rst_n,
  input  logic       reveal,
  input  logic       flag,
  input  logic [7:0] cursorPosition,
  output logic [7:0] mine_addr,
  input  logic       mine_q,
  output logic [7:0] workPosition,
  output logic [6:0] din,
  output logic       we2,
  output logic       busy,
  output logic [1:0] gState
);
  localparam int unsigned CELLS   = 256;
  localparam int unsigned WIN_CNT = CELLS - MINES;

`ifdef REVEAL_ALL_ON_LOSS_EN
  typedef enum logic [2:0] {S_IDLE, S_POP, S_SCAN, S_WRITE, S_PUSH, S_SWEEP} state_t;
  localparam state_t S_LOSS = S_SWEEP;
`else
  typedef enum logic [2:0] {S_IDLE, S_POP, S_SCAN, S_WRITE, S_PUSH} state_t;
  localparam state_t S_LOSS = S_IDLE;
`endif

  state_t       state, state_d;
  logic [255:0] revealed, flagged;
  logic [7:0]   stack [CELLS];
  logic [7:0]   sp, cur;
  logic [8:0]   rev_cnt;
  logic [3:0]   step, cnt;
  logic         cur_mine;
  logic         start_c, toggle_c, push_en_c;
  logic [7:0]   push_cell_c, top_c;
  logic [8:0]   pres_c, samp_c;
  logic [3:0]   cnt_fin_c;
`ifdef REVEAL_ALL_ON_LOSS_EN
  logic [8:0]   sweep_idx;
  logic [7:0]   sweep_cell_c;
`endif

  // Neighbour k (0..7, row-major, centre excluded) of cell c: {in_grid, address}.
  function automatic logic [8:0] nbr(input logic [7:0] c, input logic [2:0] k);
    logic signed [5:0] dr, dc, r, q;
    dr = 6'sd0;
    dc = 6'sd0;
    case (k)
      3'd0: begin dr = -6'sd1; dc = -6'sd1; end
      3'd1: begin dr = -6'sd1; dc =  6'sd0; end
      3'd2: begin dr = -6'sd1; dc =  6'sd1; end
      3'd3: begin dr =  6'sd0; dc = -6'sd1; end
      3'd4: begin dr =  6'sd0; dc =  6'sd1; end
      3'd5: begin dr =  6'sd1; dc = -6'sd1; end
      3'd6: begin dr =  6'sd1; dc =  6'sd0; end
      default: begin dr = 6'sd1; dc = 6'sd1; end
    endcase
    r = $signed({2'b00, c[7:4]}) + dr;
    q = $signed({2'b00, c[3:0]}) + dc;
    nbr = {(r >= 6'sd0) && (r <= 6'sd15) && (q >= 6'sd0) && (q <= 6'sd15), r[3:0], q[3:0]};
  endfunction

  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state plus combinational strobes for the datapath.
  always_comb begin
    state_d     = state;
    start_c     = 1'b0;
    toggle_c    = 1'b0;
    push_en_c   = 1'b0;
    push_cell_c = cursorPosition;
    top_c       = stack[sp - 8'd1];
    pres_c      = nbr(cur, 3'(step));
    samp_c      = nbr(cur, 3'(step - 4'd2));
    cnt_fin_c   = cnt + 4'(samp_c[8] & mine_q);
`ifdef REVEAL_ALL_ON_LOSS_EN
    sweep_cell_c = 8'(sweep_idx - 9'd2);
`endif
    case (state)
      S_IDLE: begin
        if (gState == 2'd0) begin
          if (reveal) begin
            start_c = !revealed[cursorPosition] && !flagged[cursorPosition];
          end else if (flag) begin
            toggle_c = !revealed[cursorPosition];
          end
        end
        push_en_c = start_c;
        if (start_c) state_d = S_POP;
      end
      S_POP:   state_d = (sp == 8'd0) ? S_IDLE : S_SCAN;
      S_SCAN:  if (step == 4'd9) state_d = S_WRITE;
      S_WRITE: begin
        if (cur_mine)                  state_d = S_LOSS;
        else if (rev_cnt == 9'(WIN_CNT)) state_d = S_IDLE;
        else if (cnt == 4'd0)          state_d = S_PUSH;
        else                           state_d = S_POP;
      end
      S_PUSH: begin
        push_cell_c = pres_c[7:0];
        push_en_c   = pres_c[8] && !revealed[pres_c[7:0]] && !flagged[pres_c[7:0]];
        if (step == 4'd7) state_d = S_POP;
      end
`ifdef REVEAL_ALL_ON_LOSS_EN
      S_SWEEP: if (sweep_idx == 9'd257) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (push_en_c) stack[sp] <= push_cell_c;
  end

  // Read pipeline: address k is presented at one edge, its mine_q is sampled two edges later.
  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      revealed     <= '0;
      flagged      <= '0;
      sp           <= '0;
      rev_cnt      <= '0;
      cur          <= '0;
      step         <= '0;
      cnt          <= '0;
      cur_mine     <= 1'b0;
      mine_addr    <= '0;
      workPosition <= '0;
      din          <= '0;
      we2          <= 1'b0;
      busy         <= 1'b0;
      gState       <= '0;
`ifdef REVEAL_ALL_ON_LOSS_EN
      sweep_idx    <= '0;
`endif
    end else begin
      we2  <= 1'b0;
      busy <= (state_d != S_IDLE);
      if (push_en_c) begin
        revealed[push_cell_c] <= 1'b1;
        sp                    <= sp + 8'd1;
      end
      case (state)
        S_IDLE: begin
          if (toggle_c) begin
            flagged[cursorPosition] <= !flagged[cursorPosition];
            we2                     <= 1'b1;
            workPosition            <= cursorPosition;
            din                     <= flagged[cursorPosition] ? 7'd11 : 7'd10;
          end
        end
        S_POP: begin
          if (sp != 8'd0) begin
            cur       <= top_c;
            mine_addr <= top_c;
            sp        <= sp - 8'd1;
            step      <= '0;
            cnt       <= '0;
            cur_mine  <= 1'b0;
          end
        end
        S_SCAN: begin
          step <= step + 4'd1;
          if (step <= 4'd7 && pres_c[8]) mine_addr <= pres_c[7:0];
          if (step == 4'd1)      cur_mine <= mine_q;
          else if (step >= 4'd2) cnt      <= cnt_fin_c;
          if (step == 4'd9) begin
            we2          <= 1'b1;
            workPosition <= cur;
            din          <= cur_mine ? 7'd9 : 7'(cnt_fin_c);
            if (!cur_mine) rev_cnt <= rev_cnt + 9'd1;
          end
        end
        S_WRITE: begin
          step <= '0;
          if (cur_mine) begin
            gState <= 2'd2;
            sp     <= '0;
`ifdef REVEAL_ALL_ON_LOSS_EN
            sweep_idx <= '0;
`endif
          end else if (rev_cnt == 9'(WIN_CNT)) begin
            gState <= 2'd1;
            sp     <= '0;
          end
        end
        S_PUSH: step <= step + 4'd1;
`ifdef REVEAL_ALL_ON_LOSS_EN
        S_SWEEP: begin
          sweep_idx <= sweep_idx + 9'd1;
          if (sweep_idx < 9'd256) mine_addr <= sweep_idx[7:0];
          if (sweep_idx >= 9'd2 && mine_q && !flagged[sweep_cell_c]) begin
            we2          <= 1'b1;
            workPosition <= sweep_cell_c;
            din          <= 7'd9;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reveal_engine.sv
// tb_reveal_engine: randomized and directed checks of reveal_engine against a BFS flood model.
module tb_reveal_engine;
  localparam int unsigned MINES = 1;

  logic       VGA_CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       reveal = 1'b0;
  logic       flag = 1'b0;
  logic [7:0] cursorPosition = '0;
  logic [7:0] mine_addr;
  logic       mine_q = 1'b0;
  logic [7:0] workPosition;
  logic [6:0] din;
  logic       we2;
  logic       busy;
  logic [1:0] gState;

  always #5 VGA_CLK = ~VGA_CLK;

  reveal_engine #(.MINES(MINES)) dut (
    .VGA_CLK(VGA_CLK), .rst_n(rst_n), .reveal(reveal), .flag(flag),
    .cursorPosition(cursorPosition), .mine_addr(mine_addr), .mine_q(mine_q),
    .workPosition(workPosition), .din(din), .we2(we2), .busy(busy), .gState(gState)
  );

  bit mines [256];
  always @(posedge VGA_CLK) mine_q <= mines[mine_addr];

  bit m_rev [256];
  bit m_flag [256];
  int m_gs, m_revn;
  int exp_cnt [256];
  int exp_din [256];
  int wr_n;
  int wr_din [256];
  int wr_seen [256];
  int n_tests = 0, n_fail = 0;

  function automatic int ncount(int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = c / 16 + dr;
        int q = c % 16 + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r < 16 && q >= 0 && q < 16 && mines[r*16+q]) n++;
      end
    return n;
  endfunction

  task automatic expect_wr(int c, int d);
    exp_cnt[c]++;
    exp_din[c] = d;
  endtask

  task automatic model_reset();
    m_gs = 0;
    m_revn = 0;
    for (int i = 0; i < 256; i++) begin
      m_rev[i] = 0; m_flag[i] = 0; exp_cnt[i] = 0; wr_seen[i] = 0; wr_din[i] = -1;
    end
  endtask

  task automatic model_reveal(int c, output bit started);
    int q[$];
    started = 0;
    if (m_gs != 0 || m_rev[c] || m_flag[c]) return;
    started = 1;
    m_rev[c] = 1;
    q.push_back(c);
    while (q.size() > 0) begin
      int x = q.pop_front();
      int n;
      if (mines[x]) begin
        expect_wr(x, 9);
        m_gs = 2;
`ifdef REVEAL_ALL_ON_LOSS_EN
        for (int i = 0; i < 256; i++) if (mines[i] && !m_flag[i]) expect_wr(i, 9);
`endif
        break;
      end
      n = ncount(x);
      expect_wr(x, n);
      m_revn++;
      if (m_revn == 256 - MINES) begin m_gs = 1; break; end
      if (n == 0)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int r = x / 16 + dr;
            int cc = x % 16 + dc;
            if (r >= 0 && r < 16 && cc >= 0 && cc < 16 && !m_rev[r*16+cc] && !m_flag[r*16+cc]) begin
              m_rev[r*16+cc] = 1;
              q.push_back(r*16+cc);
            end
          end
    end
  endtask

  task automatic model_flag(int c);
    if (m_gs == 0 && !m_rev[c]) begin
      m_flag[c] = !m_flag[c];
      expect_wr(c, m_flag[c] ? 10 : 11);
    end
  endtask

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Advance one clock; every write strobe is checked against the model here.
  task automatic step();
    @(posedge VGA_CLK);
    #1;
    if (rst_n && we2) begin
      n_tests++;
      wr_n++;
      wr_seen[workPosition]++;
      wr_din[workPosition] = din;
      if (exp_cnt[workPosition] == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cell %0d: got din %0d expected no write", workPosition, din);
      end else if (int'(din) != exp_din[workPosition]) begin
        n_fail++;
        $display("FAIL write_din cell %0d: got %0d expected %0d", workPosition, din, exp_din[workPosition]);
      end else exp_cnt[workPosition]--;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) mines[i] = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse(bit rv, bit fl, int c, output bit started);
    started = 0;
    wr_n = 0;
    cursorPosition = 8'(c);
    reveal = rv;
    flag = fl;
    if (rv) model_reveal(c, started);
    else if (fl) model_flag(c);
    step();
    reveal = 1'b0;
    flag = 1'b0;
  endtask

  task automatic finish_op();
    int guard = 0;
    int pend = 0;
    step();
    while (busy && guard < 20000) begin step(); guard++; end
    check("op_done_busy", int'(busy), 0);
    step(); step();
    for (int i = 0; i < 256; i++) pend += exp_cnt[i];
    check("pending_writes", pend, 0);
    check("gstate_model", int'(gState), m_gs);
  endtask

  initial begin
    bit st;
    int lat, ones;
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_gstate", int'(gState), 0);
    check("rst_mine_addr", int'(mine_addr), 0);

    // Single mine at 0, reveal 17: one write din=1, first write 12 cycles after the pulse.
    mines[0] = 1;
    pulse(1, 0, 17, st);
    lat = 1;
    while (!we2 && lat < 40) begin step(); lat++; end
    check("latency_interior", lat, 12);
    finish_op();
    check("c17_writes", wr_n, 1);
    check("c17_din", wr_din[17], 1);
    check("c17_gstate", int'(gState), 0);

    // Mine at 255, reveal 0: full flood to a win.
    do_reset();
    mines[255] = 1;
    pulse(1, 0, 0, st);
    finish_op();
    ones = 0;
    for (int i = 0; i < 256; i++) if (wr_seen[i] == 1) ones++;
    check("flood_writes", wr_n, 255);
    check("flood_unique", ones, 255);
    check("flood_c238", wr_din[238], 1);
    check("flood_won", int'(gState), 1);
    check("flood_busy", int'(busy), 0);

    // Mine at 16, reveal 15: no column wrap read, 16 never written.
    do_reset();
    mines[16] = 1;
    pulse(1, 0, 15, st);
    for (int i = 0; i < 12; i++) begin
      check("no_wrap_read", int'(mine_addr == 8'd16), 0);
      step();
    end
    finish_op();
    check("c15_din", wr_din[15], 0);
    check("c16_unwritten", wr_seen[16], 0);

    // Flag toggling and flagged-cell reveal protection.
    do_reset();
    pulse(0, 1, 5, st); finish_op();
    check("flag_set_writes", wr_n, 1);
    check("flag_set_din", wr_din[5], 10);
    pulse(1, 0, 5, st); finish_op();
    check("flagged_reveal_writes", wr_n, 0);
    pulse(0, 1, 5, st); finish_op();
    check("flag_clr_din", wr_din[5], 11);

    // Loss at cell 3; later pulses ignored.
    do_reset();
    mines[3] = 1; mines[200] = 1;
    pulse(1, 0, 3, st); finish_op();
    check("loss_din", wr_din[3], 9);
    check("loss_gstate", int'(gState), 2);
`ifdef REVEAL_ALL_ON_LOSS_EN
    check("loss_sweep_200", wr_seen[200], 1);
`else
    check("loss_writes", wr_n, 1);
`endif
    pulse(1, 0, 10, st); finish_op();
    check("after_loss_writes", wr_n, 0);

    // Reset during a flood.
    do_reset();
    pulse(1, 0, 0, st);
    repeat (19) step();
    rst_n = 1'b0;
    #1;
    check("midrst_we2", int'(we2), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_wp", int'(workPosition), 0);
    check("midrst_din", int'(din), 0);
    check("midrst_addr", int'(mine_addr), 0);
    check("midrst_gstate", int'(gState), 0);
    model_reset();
    step(); step();
    rst_n = 1'b1;
    wr_n = 0;
    repeat (50) step();
    check("midrst_no_write", wr_n, 0);
    check("midrst_busy_after", int'(busy), 0);

    // Randomized games, including dropped pulses while busy.
    for (int rnd = 0; rnd < 6; rnd++) begin
      int nm;
      do_reset();
      nm = (rnd == 0) ? 1 : int'($urandom_range(20, 50));
      for (int k = 0; k < nm; k++) mines[$urandom_range(0, 255)] = 1;
      for (int a = 0; a < 8; a++) begin
        int kind = int'($urandom_range(0, 3));
        int c = int'($urandom_range(0, 255));
        pulse(kind != 0, kind == 0 || kind == 3, c, st);
        if (st && $urandom_range(0, 1) == 1) begin
          bit dummy;
          step(); step(); step();
          cursorPosition = 8'($urandom_range(0, 255));
          reveal = 1'($urandom_range(0, 1));
          flag = ~reveal;
          step();
          reveal = 1'b0; flag = 1'b0;
          dummy = 0;
        end
        finish_op();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
